detect_faces_mul_arbiter: RTL and testbench

Shares one 16-bit-unsigned × 10-bit-signed → 26-bit-signed multiplier among N_REQ requesters in the face-detection datapath. Typical requesters are the weak-classifier stages multiplying a rectangle sum by a feature weight. The block arbitrates round-robin, registers the operands, computes the product in a second registered stage, and returns the result tagged with the requester index. It sits between the classifier evaluation units and the shared multiplier core, and owns all sequencing of that core.

---
 rtl/detect_faces_mul_pkg.sv | 19 +
 rtl/detect_faces_mul_arbiter_if.sv | 26 ++
 rtl/detectFaces_mul_16ns_10s_26_1_1.sv | 18 +
 rtl/rr_arbiter.sv | 46 ++++
 rtl/detect_faces_mul_arbiter.sv | 98 +++++++++
 tb/tb_detect_faces_mul_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/detect_faces_mul_pkg.sv
// Shared widths and operand/result bundles for the face-detection multiplier arbiter.
package detect_faces_mul_pkg;

   localparam int MUL_A_W  = 16;
   localparam int MUL_B_W  = 10;
   localparam int MUL_P_W  = 26;
   localparam int MUL_ID_W = 3;   // wide enough for up to 8 requesters

   typedef struct packed {
      logic        [MUL_A_W-1:0] a;
      logic signed [MUL_B_W-1:0] b;
   } mul_req_t;

   typedef struct packed {
      logic        [MUL_ID_W-1:0] id;
      logic signed [MUL_P_W-1:0]  product;
   } mul_rsp_t;

endpackage

// File: rtl/detect_faces_mul_arbiter_if.sv
// Requester-side operand bus and consumer-side result bus of the shared multiplier.
interface detect_faces_mul_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
);
   import detect_faces_mul_pkg::*;

   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_ready;
   logic [MUL_A_W*N_REQ-1:0] req_a;
   logic [MUL_B_W*N_REQ-1:0] req_b;
   logic                     rsp_valid;
   logic                     rsp_ready;
   logic [ID_W-1:0]          rsp_id;
   logic [MUL_P_W-1:0]       rsp_product;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_product
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_product
   );
endinterface

// File: rtl/detectFaces_mul_16ns_10s_26_1_1.sv
// Combinational unsigned x signed multiplier core; zero latency, no flow control.
module detectFaces_mul_16ns_10s_26_1_1 #(
   parameter int din0_WIDTH = 16,
   parameter int din1_WIDTH = 10,
   parameter int dout_WIDTH = 26
) (
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic [dout_WIDTH-1:0] dout
);
   logic signed [dout_WIDTH-1:0] a_ext;
   logic signed [dout_WIDTH-1:0] b_ext;

   // din0 is unsigned, so it gets a zero sign bit before extension
   assign a_ext = dout_WIDTH'($signed({1'b0, din0}));
   assign b_ext = dout_WIDTH'($signed(din1));
   assign dout  = a_ext * b_ext;
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin winner select among valid requesters; grant is combinational, pointer
// moves past the winner on each grant. Grants nothing while en is low.
module rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_id,
   output logic             gnt_vld
);
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W:0]   idx_sum;
   logic [ID_W-1:0] idx;

   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_vld = 1'b0;
      idx_sum = '0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (idx_sum >= (ID_W+1)'(N_REQ)) begin
            idx_sum = idx_sum - (ID_W+1)'(N_REQ);
         end
         idx = idx_sum[ID_W-1:0];
         if (en && !gnt_vld && req[idx]) begin
            gnt_vld  = 1'b1;
            gnt_id   = idx;
            gnt[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (gnt_vld) begin
         rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + ID_W'(1);
      end
   end
endmodule

// File: rtl/detect_faces_mul_arbiter.sv
// Round-robin share of one 16u x 10s multiplier; 2-cycle latency, 1 op/cycle.
// A stalled consumer freezes both stages; requests are refused only when both are full.
module detect_faces_mul_arbiter
   import detect_faces_mul_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input logic                      ap_clk,
   input logic                      ap_rst,
   detect_faces_mul_arbiter_if.slave bus
);
   logic               adv1;
   logic               adv2;
   logic               arb_en;
   logic [N_REQ-1:0]   gnt;
   logic [ID_W-1:0]    gnt_id;
   logic               gnt_vld;
   mul_req_t           sel_req;

   logic               s1_valid;
   logic [ID_W-1:0]    s1_id;
   mul_req_t           s1_req;
   logic [MUL_P_W-1:0] prod;

   logic               rsp_valid_q;
   logic [ID_W-1:0]    rsp_id_q;
   logic [MUL_P_W-1:0] rsp_product_q;

   assign adv2   = !rsp_valid_q || bus.rsp_ready;
   assign adv1   = !s1_valid || adv2;
   assign arb_en = adv1 && !ap_rst;

   rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_arbiter (
      .clk     (ap_clk),
      .rst     (ap_rst),
      .en      (arb_en),
      .req     (bus.req_valid),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld)
   );

   assign bus.req_ready = gnt;

   always_comb begin
      sel_req = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_id == ID_W'(i)) begin
            sel_req.a = bus.req_a[MUL_A_W*i +: MUL_A_W];
            sel_req.b = bus.req_b[MUL_B_W*i +: MUL_B_W];
         end
      end
   end

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_req   <= '0;
      end else if (adv1) begin
         s1_valid <= gnt_vld;
         if (gnt_vld) begin
            s1_id  <= gnt_id;
            s1_req <= sel_req;
         end
      end
   end

   detectFaces_mul_16ns_10s_26_1_1 #(
      .din0_WIDTH (MUL_A_W),
      .din1_WIDTH (MUL_B_W),
      .dout_WIDTH (MUL_P_W)
   ) u_mul (
      .din0 (s1_req.a),
      .din1 (s1_req.b),
      .dout (prod)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= '0;
         rsp_product_q <= '0;
      end else if (adv2) begin
         rsp_valid_q   <= s1_valid;
         rsp_id_q      <= s1_id;
         rsp_product_q <= prod;
      end
   end

   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_product = rsp_product_q;
endmodule

// File: tb/tb_detect_faces_mul_arbiter.sv
// Bench for detect_faces_mul_arbiter: directed scenarios plus a random run against a
// queue-based model of accepted operations.
module tb_detect_faces_mul_arbiter;
   import detect_faces_mul_pkg::*;

   localparam int N = 4;

   logic ap_clk = 1'b0;
   logic ap_rst;
   always #5 ap_clk = ~ap_clk;

   detect_faces_mul_arbiter_if #(.N_REQ(N), .ID_W(2)) bus();

   detect_faces_mul_arbiter #(.N_REQ(N), .ID_W(2)) dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
   );

   logic [N-1:0]       rv;
   logic [15:0]        ra [N];
   logic signed [9:0]  rb [N];
   logic               rr;

   always_comb begin
      bus.req_valid = rv;
      bus.rsp_ready = rr;
      bus.req_a     = '0;
      bus.req_b     = '0;
      for (int i = 0; i < N; i++) begin
         bus.req_a[16*i +: 16] = ra[i];
         bus.req_b[10*i +: 10] = rb[i];
      end
   end

   int checks   = 0;
   int failures = 0;

   // Model: ops accepted but not yet consumed, with the cycle each was accepted.
   int         ptr = 0;
   int         cyc = 0;
   int         mode = 0;       // 0: requester drops valid after transfer, 1: keeps it
   mul_rsp_t   q_rsp[$];
   int         q_t[$];
   int         e_win;
   logic [N-1:0] e_ready;
   logic       e_rvld;
   mul_rsp_t   e_rsp;

   task automatic model_eval();
      e_win   = -1;
      e_ready = '0;
      if (!ap_rst && (q_rsp.size() < 2 || rr)) begin
         for (int k = 0; k < N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (e_win < 0 && rv[i]) e_win = i;
         end
      end
      if (e_win >= 0) e_ready[e_win] = 1'b1;
      e_rvld = 1'b0;
      e_rsp  = '0;
      if (q_rsp.size() > 0) begin
         if (cyc >= q_t[0] + 2) begin
            e_rvld = 1'b1;
            e_rsp  = q_rsp[0];
         end
      end
   endtask

   task automatic model_commit();
      mul_rsp_t r;
      if (ap_rst) begin
         q_rsp.delete();
         q_t.delete();
         ptr = 0;
      end else begin
         if (e_rvld && rr) begin
            void'(q_rsp.pop_front());
            void'(q_t.pop_front());
         end
         if (e_win >= 0) begin
            r.id      = 3'(e_win);
            r.product = 26'(int'(ra[e_win]) * int'(rb[e_win]));
            q_rsp.push_back(r);
            q_t.push_back(cyc);
            ptr = (e_win + 1) % N;
            if (mode == 0) rv[e_win] = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic test_reset();
      string tn = "reset";
      ap_rst = 1'b1; rr = 1'b1; mode = 0; rv = '1;
      for (int i = 0; i < N; i++) begin ra[i] = 16'($urandom); rb[i] = 10'($urandom); end
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin ap_rst = 1'b0; rv = '0; end
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         if (k == 2) begin
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 || bus.rsp_product !== 26'd0) begin
               failures++; $display("FAIL %s outputs got v=%b id=%0d p=%0d exp 0/0/0", tn, bus.rsp_valid, bus.rsp_id, bus.rsp_product);
            end
         end
         @(posedge ap_clk); #1;
         model_commit();
      end
   endtask

   task automatic test_single();
      string tn = "single";
      mode = 0; rr = 1'b1; rv = 4'b0001; ra[0] = 16'd1000; rb[0] = -10'sd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         checks++;
         if (bus.rsp_valid !== e_rvld) begin failures++; $display("FAIL %s rsp_valid k=%0d got=%b exp=%b", tn, k, bus.rsp_valid, e_rvld); end
         if (e_rvld) begin
            checks++;
            if (bus.rsp_id !== e_rsp.id[1:0] || bus.rsp_product !== e_rsp.product) begin failures++; $display("FAIL %s rsp k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), e_rsp.id, e_rsp.product); end
         end
         if (k == 0) begin
            checks++;
            if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL %s same_cycle_grant got=%b exp=0001", tn, bus.req_ready); end
         end
         if (k == 2) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || int'($signed(bus.rsp_product)) != -3000) begin
               failures++; $display("FAIL %s result got v=%b id=%0d p=%0d exp 1/0/-3000", tn, bus.rsp_valid, bus.rsp_id, $signed(bus.rsp_product));
            end
         end
         @(posedge ap_clk); #1;
         model_commit();
      end
   endtask

   task automatic test_extremes();
      string tn = "extremes";
      mode = 0; rr = 1'b1; rv = 4'b0001; ra[0] = 16'hFFFF; rb[0] = -10'sd512;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin rv[0] = 1'b1; rb[0] = 10'sd511; end
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         checks++;
         if (bus.rsp_valid !== e_rvld) begin failures++; $display("FAIL %s rsp_valid k=%0d got=%b exp=%b", tn, k, bus.rsp_valid, e_rvld); end
         if (e_rvld) begin
            checks++;
            if (bus.rsp_id !== e_rsp.id[1:0] || bus.rsp_product !== e_rsp.product) begin failures++; $display("FAIL %s rsp k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), e_rsp.id, e_rsp.product); end
         end
         if (k == 2 || k == 3) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || int'($signed(bus.rsp_product)) != ((k == 2) ? -33553920 : 33488385)) begin
               failures++; $display("FAIL %s product k=%0d got v=%b p=%0d exp %0d", tn, k, bus.rsp_valid, $signed(bus.rsp_product), (k == 2) ? -33553920 : 33488385);
            end
         end
         @(posedge ap_clk); #1;
         model_commit();
      end
   endtask

   task automatic test_fairness();
      string tn = "fairness";
      logic [N-1:0] exp_g;
      ap_rst = 1'b1; rv = '0; rr = 1'b1;
      @(negedge ap_clk); model_eval(); @(posedge ap_clk); #1; model_commit();
      ap_rst = 1'b0; mode = 1; rv = '1;
      for (int i = 0; i < N; i++) begin ra[i] = 16'd10; rb[i] = 10'(i + 1); end
      for (int k = 0; k < 14; k++) begin
         if (k == 12) rv = '0;
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         checks++;
         if (bus.rsp_valid !== e_rvld) begin failures++; $display("FAIL %s rsp_valid k=%0d got=%b exp=%b", tn, k, bus.rsp_valid, e_rvld); end
         if (e_rvld) begin
            checks++;
            if (bus.rsp_id !== e_rsp.id[1:0] || bus.rsp_product !== e_rsp.product) begin failures++; $display("FAIL %s rsp k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), e_rsp.id, e_rsp.product); end
         end
         if (k < 12) begin
            exp_g = 4'b0001 << (k % 4);
            checks++;
            if (bus.req_ready !== exp_g) begin failures++; $display("FAIL %s rotation k=%0d got=%b exp=%b", tn, k, bus.req_ready, exp_g); end
         end
         if (k >= 2) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || int'(bus.rsp_id) != (k - 2) % 4 || int'($signed(bus.rsp_product)) != 10 * ((k - 2) % 4 + 1)) begin
               failures++; $display("FAIL %s sequence k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), (k - 2) % 4, 10 * ((k - 2) % 4 + 1));
            end
         end
         @(posedge ap_clk); #1;
         model_commit();
      end
   endtask

   task automatic test_backpressure();
      string tn = "backpressure";
      int p0;
      int stall_grants = 0;
      int n_rsp = 0;
      ap_rst = 1'b1; rv = '0; rr = 1'b1;
      @(negedge ap_clk); model_eval(); @(posedge ap_clk); #1; model_commit();
      ap_rst = 1'b0; mode = 0; rv = 4'b0111;
      for (int i = 0; i < N; i++) begin ra[i] = 16'($urandom); rb[i] = 10'($urandom); end
      p0 = int'(ra[0]) * int'(rb[0]);
      for (int k = 0; k < 10; k++) begin
         rr = (k >= 5);
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         checks++;
         if (bus.rsp_valid !== e_rvld) begin failures++; $display("FAIL %s rsp_valid k=%0d got=%b exp=%b", tn, k, bus.rsp_valid, e_rvld); end
         if (e_rvld) begin
            checks++;
            if (bus.rsp_id !== e_rsp.id[1:0] || bus.rsp_product !== e_rsp.product) begin failures++; $display("FAIL %s rsp k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), e_rsp.id, e_rsp.product); end
         end
         if (k >= 2 && k <= 4) begin
            checks++;
            if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b1 || int'($signed(bus.rsp_product)) != p0) begin
               failures++; $display("FAIL %s hold k=%0d got rdy=%b v=%b p=%0d exp 0000/1/%0d", tn, k, bus.req_ready, bus.rsp_valid, $signed(bus.rsp_product), p0);
            end
         end
         if (k < 5 && bus.req_ready != '0) stall_grants++;
         if (bus.rsp_valid === 1'b1 && rr) n_rsp++;
         @(posedge ap_clk); #1;
         model_commit();
      end
      checks++;
      if (stall_grants != 2) begin failures++; $display("FAIL %s in_flight got=%0d exp=2", tn, stall_grants); end
      checks++;
      if (n_rsp != 3) begin failures++; $display("FAIL %s responses got=%0d exp=3", tn, n_rsp); end
   endtask

   task automatic test_pointer();
      string tn = "pointer";
      ap_rst = 1'b1; rv = '0; rr = 1'b1;
      @(negedge ap_clk); model_eval(); @(posedge ap_clk); #1; model_commit();
      ap_rst = 1'b0; mode = 1; rv = 4'b0100;
      for (int i = 0; i < N; i++) begin ra[i] = 16'($urandom); rb[i] = 10'($urandom); end
      for (int k = 0; k < 8; k++) begin
         if (k == 3) begin mode = 0; rv = 4'b1010; end
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         checks++;
         if (bus.rsp_valid !== e_rvld) begin failures++; $display("FAIL %s rsp_valid k=%0d got=%b exp=%b", tn, k, bus.rsp_valid, e_rvld); end
         if (e_rvld) begin
            checks++;
            if (bus.rsp_id !== e_rsp.id[1:0] || bus.rsp_product !== e_rsp.product) begin failures++; $display("FAIL %s rsp k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), e_rsp.id, e_rsp.product); end
         end
         if (k == 3 || k == 4) begin
            checks++;
            if (bus.req_ready !== ((k == 3) ? 4'b1000 : 4'b0010)) begin failures++; $display("FAIL %s order k=%0d got=%b exp=%b", tn, k, bus.req_ready, (k == 3) ? 4'b1000 : 4'b0010); end
         end
         @(posedge ap_clk); #1;
         model_commit();
      end
   endtask

   task automatic test_reset_midflight();
      string tn = "reset_midflight";
      mode = 0; rr = 1'b1; rv = 4'b0011;
      for (int i = 0; i < N; i++) begin ra[i] = 16'($urandom); rb[i] = 10'($urandom); end
      for (int k = 0; k < 9; k++) begin
         if (k == 2) begin ap_rst = 1'b1; rr = 1'b0; end
         if (k == 3) begin ap_rst = 1'b0; rr = 1'b1; end
         if (k == 4) rv = 4'b1010;
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         checks++;
         if (bus.rsp_valid !== e_rvld) begin failures++; $display("FAIL %s rsp_valid k=%0d got=%b exp=%b", tn, k, bus.rsp_valid, e_rvld); end
         if (e_rvld) begin
            checks++;
            if (bus.rsp_id !== e_rsp.id[1:0] || bus.rsp_product !== e_rsp.product) begin failures++; $display("FAIL %s rsp k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), e_rsp.id, e_rsp.product); end
         end
         if (k == 3) begin
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_product !== 26'd0) begin failures++; $display("FAIL %s cleared got v=%b p=%0d exp 0/0", tn, bus.rsp_valid, bus.rsp_product); end
         end
         if (k == 4) begin
            checks++;
            if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL %s ptr_reset got=%b exp=0010", tn, bus.req_ready); end
         end
         @(posedge ap_clk); #1;
         model_commit();
      end
   endtask

   task automatic test_random();
      string tn = "random";
      mode = 0;
      for (int k = 0; k < 604; k++) begin
         rr = (k >= 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (k < 600) begin
            for (int i = 0; i < N; i++) begin
               if (!rv[i] && $urandom_range(0, 1) == 1) begin
                  rv[i] = 1'b1;
                  ra[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
                  rb[i] = 10'($urandom);
               end
            end
         end else begin
            rv = '0;
         end
         @(negedge ap_clk);
         model_eval();
         checks++;
         if (bus.req_ready !== e_ready) begin failures++; $display("FAIL %s req_ready k=%0d got=%b exp=%b", tn, k, bus.req_ready, e_ready); end
         checks++;
         if (bus.rsp_valid !== e_rvld) begin failures++; $display("FAIL %s rsp_valid k=%0d got=%b exp=%b", tn, k, bus.rsp_valid, e_rvld); end
         if (e_rvld) begin
            checks++;
            if (bus.rsp_id !== e_rsp.id[1:0] || bus.rsp_product !== e_rsp.product) begin failures++; $display("FAIL %s rsp k=%0d got id=%0d p=%0d exp id=%0d p=%0d", tn, k, bus.rsp_id, $signed(bus.rsp_product), e_rsp.id, e_rsp.product); end
         end
         @(posedge ap_clk); #1;
         model_commit();
      end
   endtask

   initial begin
      ap_rst = 1'b1;
      rv     = '0;
      rr     = 1'b0;
      for (int i = 0; i < N; i++) begin ra[i] = '0; rb[i] = '0; end
      test_reset();
      test_single();
      test_extremes();
      test_fairness();
      test_backpressure();
      test_pointer();
      test_reset_midflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
